// File: rtl/player_status_pkg.sv
// Shared types and defaults for the SD/WAV player status sequencer.
// The state encoding doubles as the 4-bit code driven to the 7-segment decoder.
package player_status_pkg;

    typedef enum logic [3:0] {
        ST_INIT     = 4'h0,
        ST_WAIT_KEY = 4'h1,
        ST_SEARCH   = 4'h2,
        ST_PLAY     = 4'h3,
        ST_ERROR    = 4'hF
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int SEARCH_TIMEOUT_DEF  = 250_000_000;

    // States that depend on the card being present; losing it here forces ERROR.
    function automatic logic needs_card(input state_t s);
        return (s == ST_WAIT_KEY) || (s == ST_SEARCH) || (s == ST_PLAY);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises the raw active-low key and emits a one-cycle pulse on a
// debounced press (1->0); releases are filtered but produce no pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Counter tracks consecutive samples that disagree with the debounced level;
    // any sample matching the level restarts it.
    always_comb begin
        sync_d  = {sync_q[0], key_n};
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                press_d = level_q & ~sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign key_press = press_q;

endmodule

// File: rtl/player_status_fsm.sv
// SD/WAV player sequencer: card init -> wait for key -> search WAV -> play.
// Strobes are registered one-cycle pulses, coincident with the new state_code.
module player_status_fsm
    import player_status_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SEARCH_TIMEOUT  = SEARCH_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic       sd_init_done,
    input  logic       file_found,
    input  logic       play_done,
    output logic       search_start,
    output logic       play_en,
    output logic       sd_reinit,
    output logic [3:0] state_code
);

    localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(SEARCH_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          search_start_q, search_start_d;
    logic          sd_reinit_q, sd_reinit_d;
    logic          play_en_q, play_en_d;
    logic          key_press;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .key_press (key_press)
    );

    always_comb begin
        state_d        = state_q;
        tmo_d          = '0;
        search_start_d = 1'b0;
        sd_reinit_d    = 1'b0;
        if (needs_card(state_q) && !sd_init_done) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (sd_init_done) state_d = ST_WAIT_KEY;
                end
                ST_WAIT_KEY: begin
                    if (key_press) begin
                        state_d        = ST_SEARCH;
                        search_start_d = 1'b1;
                    end
                end
                // A file arriving on the timeout cycle still counts as found.
                ST_SEARCH: begin
                    if (file_found)              state_d = ST_PLAY;
                    else if (tmo_q == TMO_LAST)  state_d = ST_ERROR;
                    else                         tmo_d   = tmo_q + TMO_ONE;
                end
                ST_PLAY: begin
                    if (play_done || key_press) state_d = ST_WAIT_KEY;
                end
                ST_ERROR: begin
                    if (key_press) begin
                        state_d     = ST_INIT;
                        sd_reinit_d = 1'b1;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
        play_en_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_INIT;
            tmo_q          <= '0;
            search_start_q <= 1'b0;
            sd_reinit_q    <= 1'b0;
            play_en_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            search_start_q <= search_start_d;
            sd_reinit_q    <= sd_reinit_d;
            play_en_q      <= play_en_d;
        end
    end

    assign state_code   = state_q;
    assign search_start = search_start_q;
    assign sd_reinit    = sd_reinit_q;
    assign play_en      = play_en_q;

endmodule
